// File: rtl/bcd_scan_display.sv
// bcd_scan_display: time-multiplexed driver for a 3-digit common-anode 7-segment display.
//
// A digit triple is captured on load_i into a pending register. It is committed to the
// display registers only at a frame boundary, so one scan never mixes old and new digits.
// The three digits are scanned at DIV clocks per slot. Leading zeros are blanked when
// LZB=1. Codes 10-15 show a dash.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   load_i   capture hund_i/ten_i/one_i at this edge
//   hund_i   hundreds BCD digit
//   ten_i    tens BCD digit
//   one_i    units BCD digit
//   en_i     display enable; 0 forces the display dark
//   an_o     active-low digit enables {hund, ten, one}
//   seg_o    active-low segments {g,f,e,d,c,b,a}
//   frame_o  one-cycle pulse after each frame boundary edge

module bcd_scan_display #(
    parameter int unsigned DIV = 50000,
    parameter bit          LZB = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] hund_i,
    input  logic [3:0] ten_i,
    input  logic [3:0] one_i,
    input  logic       en_i,
    output logic [2:0] an_o,
    output logic [6:0] seg_o,
    output logic       frame_o
);

    localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DIV - 1);

    typedef enum logic [1:0] {
        StHund = 2'd0,
        StTen  = 2'd1,
        StOne  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      pend_h_q, pend_h_d, pend_t_q, pend_t_d, pend_o_q, pend_o_d;
    logic            pend_v_q, pend_v_d;
    logic [3:0]      disp_h_q, disp_h_d, disp_t_q, disp_t_d, disp_o_q, disp_o_d;
    logic [2:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            frame_q, frame_d;

    logic            slot_end;
    logic            boundary;
    logic [3:0]      cur_digit;
    logic            cur_blank;
    logic [2:0]      cur_an;

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F; // invalid BCD shows a dash
        endcase
        return s;
    endfunction

    // Prescaler and slot sequencing
    always_comb begin
        slot_end = (cnt_q == LastCnt);
        boundary = slot_end && (state_q == StOne);
        cnt_d    = slot_end ? '0 : cnt_q + CntW'(1);
        state_d  = state_q;
        if (slot_end) begin
            case (state_q)
                StHund:  state_d = StTen;
                StTen:   state_d = StOne;
                default: state_d = StHund;
            endcase
        end
    end

    // Capture and commit. A load on the boundary edge bypasses the pending register and
    // discards whatever was pending.
    always_comb begin
        pend_h_d = pend_h_q;
        pend_t_d = pend_t_q;
        pend_o_d = pend_o_q;
        pend_v_d = pend_v_q;
        disp_h_d = disp_h_q;
        disp_t_d = disp_t_q;
        disp_o_d = disp_o_q;
        frame_d  = boundary;

        if (load_i) begin
            pend_h_d = hund_i;
            pend_t_d = ten_i;
            pend_o_d = one_i;
        end

        if (boundary) begin
            pend_v_d = 1'b0;
            if (load_i) begin
                disp_h_d = hund_i;
                disp_t_d = ten_i;
                disp_o_d = one_i;
            end else if (pend_v_q) begin
                disp_h_d = pend_h_q;
                disp_t_d = pend_t_q;
                disp_o_d = pend_o_q;
            end
        end else if (load_i) begin
            pend_v_d = 1'b1;
        end
    end

    // Slot decode; outputs are registered so they lag state/display by one clock
    always_comb begin
        cur_digit = disp_o_q;
        cur_blank = 1'b0;
        cur_an    = 3'b110;
        case (state_q)
            StHund: begin
                cur_digit = disp_h_q;
                cur_blank = LZB && (disp_h_q == 4'd0);
                cur_an    = 3'b011;
            end
            StTen: begin
                cur_digit = disp_t_q;
                cur_blank = LZB && (disp_h_q == 4'd0) && (disp_t_q == 4'd0);
                cur_an    = 3'b101;
            end
            default: begin
                cur_digit = disp_o_q;
                cur_blank = 1'b0;
                cur_an    = 3'b110;
            end
        endcase

        if (!en_i || cur_blank) begin
            an_d  = 3'b111;
            seg_d = 7'h7F;
        end else begin
            an_d  = cur_an;
            seg_d = encode(cur_digit);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            state_q  <= StHund;
            pend_h_q <= 4'd0;
            pend_t_q <= 4'd0;
            pend_o_q <= 4'd0;
            pend_v_q <= 1'b0;
            disp_h_q <= 4'd0;
            disp_t_q <= 4'd0;
            disp_o_q <= 4'd0;
            an_q     <= 3'b111;
            seg_q    <= 7'h7F;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            pend_h_q <= pend_h_d;
            pend_t_q <= pend_t_d;
            pend_o_q <= pend_o_d;
            pend_v_q <= pend_v_d;
            disp_h_q <= disp_h_d;
            disp_t_q <= disp_t_d;
            disp_o_q <= disp_o_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            frame_q  <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display with DIV=4. Two instances run side by side,
// one with leading-zero blanking and one without, against a cycle-level reference model
// that tracks edges since reset, the displayed triple and the pending triple.

module tb_bcd_scan_display;

    localparam int DIV = 4;
    localparam int FRAME = 3 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] hund = 4'd0;
    logic [3:0] ten = 4'd0;
    logic [3:0] one = 4'd0;
    logic       en = 1'b1;

    logic [2:0] an_b, an_n;
    logic [6:0] seg_b, seg_n;
    logic       frame_b, frame_n;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    int         m = 0;          // clean edges since reset
    logic [3:0] dsp [3];        // displayed digits, [0]=hundreds
    logic [3:0] pnd [3];
    logic       pv = 1'b0;
    logic [2:0] exp_an_b, exp_an_n;
    logic [6:0] exp_seg_b, exp_seg_n;
    logic       exp_frame;

    always #5 clk = ~clk;

    bcd_scan_display #(.DIV(DIV), .LZB(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .load_i(load), .hund_i(hund), .ten_i(ten), .one_i(one),
        .en_i(en), .an_o(an_b), .seg_o(seg_b), .frame_o(frame_b)
    );

    bcd_scan_display #(.DIV(DIV), .LZB(1'b0)) dut_nb (
        .clk_i(clk), .rst_i(rst), .load_i(load), .hund_i(hund), .ten_i(ten), .one_i(one),
        .en_i(en), .an_o(an_n), .seg_o(seg_n), .frame_o(frame_n)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tab [10];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (d < 4'd10) ? tab[d] : 7'h3F;
    endfunction

    // Drive inputs, take one edge, advance the model, then settle past the edge.
    task automatic tick(input logic r, input logic ld, input logic [3:0] h, input logic [3:0] t,
                        input logic [3:0] o, input logic e);
        int  slot;
        bit  bnd, bh, bt, lit;
        rst = r; load = ld; hund = h; ten = t; one = o; en = e;
        @(posedge clk);
        if (r) begin
            m = 0;
            for (int i = 0; i < 3; i++) begin dsp[i] = 4'd0; pnd[i] = 4'd0; end
            pv = 1'b0;
            exp_an_b = 3'b111; exp_seg_b = 7'h7F;
            exp_an_n = 3'b111; exp_seg_n = 7'h7F;
            exp_frame = 1'b0;
        end else begin
            slot = (m / DIV) % 3;
            bnd  = (m % FRAME) == FRAME - 1;
            bh   = dsp[0] == 4'd0;
            bt   = bh && dsp[1] == 4'd0;
            lit  = e && !((slot == 0 && bh) || (slot == 1 && bt));
            exp_an_b  = lit ? ~(3'b100 >> slot) : 3'b111;
            exp_seg_b = lit ? seg_of(dsp[slot]) : 7'h7F;
            exp_an_n  = e ? ~(3'b100 >> slot) : 3'b111;
            exp_seg_n = e ? seg_of(dsp[slot]) : 7'h7F;
            exp_frame = bnd;
            if (bnd) begin
                if (ld) begin
                    dsp[0] = h; dsp[1] = t; dsp[2] = o;
                end else if (pv) begin
                    dsp = pnd;
                end
                pv = 1'b0;
            end else if (ld) begin
                pnd[0] = h; pnd[1] = t; pnd[2] = o;
                pv = 1'b1;
            end
            m++;
        end
        #1;
    endtask

    task automatic test_reset;
        int pulses = 0;
        tick(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        n_chk++;
        if ({an_b, seg_b, frame_b} !== {3'b111, 7'h7F, 1'b0})
            $display("FAIL reset_state: got an=%b seg=%h frame=%b, need 111/7f/0",
                     an_b, seg_b, frame_b);
        else n_pass++;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
            if (frame_b) pulses++;
            n_chk++;
            if ({an_b, seg_b, frame_b} !== {exp_an_b, exp_seg_b, exp_frame})
                $display("FAIL reset_scan cyc%0d: got %b/%h/%b, need %b/%h/%b", i,
                         an_b, seg_b, frame_b, exp_an_b, exp_seg_b, exp_frame);
            else n_pass++;
            // units slot of an all-zero display
            if ((i % FRAME) == 2 * DIV + 1) begin
                n_chk++;
                if ({an_b, seg_b} !== {3'b110, 7'h40})
                    $display("FAIL reset_units cyc%0d: got %b/%h, need 110/40", i, an_b, seg_b);
                else n_pass++;
            end
        end
        n_chk++;
        if (pulses != 2) $display("FAIL reset_frames: got %0d pulses, need 2", pulses);
        else n_pass++;
    endtask

    // Loads a list of triples, one per frame at a random mid-frame point, checking both DUTs.
    task automatic test_load_commit(input string name, input logic [11:0] trip [$]);
        foreach (trip[k]) begin
            int at = $urandom_range(0, FRAME - 2);
            for (int i = 0; i < 3 * FRAME; i++) begin
                bit ld = (i == at);
                tick(1'b0, ld, trip[k][11:8], trip[k][7:4], trip[k][3:0], 1'b1);
                n_chk += 2;
                if ({an_b, seg_b, frame_b} !== {exp_an_b, exp_seg_b, exp_frame})
                    $display("FAIL %s lzb1 #%0d cyc%0d: got %b/%h/%b, need %b/%h/%b", name, k, i,
                             an_b, seg_b, frame_b, exp_an_b, exp_seg_b, exp_frame);
                else n_pass++;
                if ({an_n, seg_n, frame_n} !== {exp_an_n, exp_seg_n, exp_frame})
                    $display("FAIL %s lzb0 #%0d cyc%0d: got %b/%h/%b, need %b/%h/%b", name, k, i,
                             an_n, seg_n, frame_n, exp_an_n, exp_seg_n, exp_frame);
                else n_pass++;
            end
        end
    endtask

    task automatic test_collisions;
        for (int g = 0; g < FRAME && (m % FRAME) != 2; g++) tick(1'b0, 1'b0, 0, 0, 0, 1'b1);
        tick(1'b0, 1'b1, 4'd4, 4'd5, 4'd6, 1'b1);
        tick(1'b0, 1'b1, 4'd7, 4'd8, 4'd9, 1'b1);
        // pending 9,9,9 then a load exactly on the boundary edge
        for (int g = 0; g < FRAME && (m % FRAME) != 6; g++) tick(1'b0, 1'b0, 0, 0, 0, 1'b1);
        tick(1'b0, 1'b1, 4'd9, 4'd9, 4'd9, 1'b1);
        for (int g = 0; g < FRAME && (m % FRAME) != FRAME - 1; g++)
            tick(1'b0, 1'b0, 0, 0, 0, 1'b1);
        tick(1'b0, 1'b1, 4'd2, 4'd2, 4'd2, 1'b1);
        n_chk++;
        if (dut.pend_v_q !== 1'b0) $display("FAIL boundary_pend_v: got %b, need 0", dut.pend_v_q);
        else n_pass++;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
            n_chk++;
            if ({an_b, seg_b, frame_b} !== {exp_an_b, exp_seg_b, exp_frame})
                $display("FAIL collide cyc%0d: got %b/%h/%b, need %b/%h/%b", i,
                         an_b, seg_b, frame_b, exp_an_b, exp_seg_b, exp_frame);
            else n_pass++;
            if (i == 1) begin
                n_chk++;
                if ({an_b, seg_b} !== {3'b011, 7'h24})
                    $display("FAIL boundary_load_hund: got %b/%h, need 011/24", an_b, seg_b);
                else n_pass++;
            end
        end
    endtask

    task automatic test_enable;
        int pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
            if (frame_b) pulses++;
            n_chk++;
            if ({an_b, seg_b, an_n, seg_n} !== {3'b111, 7'h7F, 3'b111, 7'h7F} ||
                frame_b !== exp_frame)
                $display("FAIL enable_dark cyc%0d: got %b/%h/%b, need 111/7f/%b", i,
                         an_b, seg_b, frame_b, exp_frame);
            else n_pass++;
        end
        n_chk++;
        if (pulses < 1) $display("FAIL enable_frame: got %0d pulses, need >=1", pulses);
        else n_pass++;
    endtask

    task automatic test_mid_reset;
        tick(1'b0, 1'b1, 4'd5, 4'd6, 4'd7, 1'b1);
        for (int g = 0; g < FRAME && ((m / DIV) % 3) != 1; g++) tick(1'b0, 1'b0, 0, 0, 0, 1'b1);
        tick(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        n_chk++;
        if ({an_b, seg_b, frame_b} !== {3'b111, 7'h7F, 1'b0})
            $display("FAIL midreset_state: got %b/%h/%b, need 111/7f/0", an_b, seg_b, frame_b);
        else n_pass++;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
            n_chk++;
            if ({an_b, seg_b, frame_b} !== {exp_an_b, exp_seg_b, exp_frame})
                $display("FAIL midreset_scan cyc%0d: got %b/%h/%b, need %b/%h/%b", i,
                         an_b, seg_b, frame_b, exp_an_b, exp_seg_b, exp_frame);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 900; i++) begin
            logic r  = ($urandom_range(0, 299) == 0);
            logic ld = ($urandom_range(0, 5) == 0);
            logic e  = ($urandom_range(0, 7) != 0);
            tick(r, ld, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), e);
            n_chk += 2;
            if ({an_b, seg_b, frame_b} !== {exp_an_b, exp_seg_b, exp_frame})
                $display("FAIL random lzb1 cyc%0d: got %b/%h/%b, need %b/%h/%b", i,
                         an_b, seg_b, frame_b, exp_an_b, exp_seg_b, exp_frame);
            else n_pass++;
            if ({an_n, seg_n, frame_n} !== {exp_an_n, exp_seg_n, exp_frame})
                $display("FAIL random lzb0 cyc%0d: got %b/%h/%b, need %b/%h/%b", i,
                         an_n, seg_n, frame_n, exp_an_n, exp_seg_n, exp_frame);
            else n_pass++;
        end
    endtask

    initial begin
        logic [11:0] basic [$];
        logic [11:0] blank [$];
        basic = '{12'h123};
        blank = '{12'h007, 12'h050, 12'h0C1, 12'h000, 12'hFA9};
        test_reset();
        test_load_commit("load_commit", basic);
        test_load_commit("blank_dash", blank);
        test_collisions();
        test_enable();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed driver for a 3-digit common-anode 7-segment display, fed by the binary-to-BCD stage's `hund`/`ten`/`one` digits. It captures a digit triple on a load strobe, holds it in a pending register, and commits it to the display only at a frame boundary so a scan never mixes old and new digits. It then scans the three digits at a programmable rate, with leading-zero blanking and a dash for invalid BCD codes.

## Interface
- `DIV`, 50000: clock cycles per digit slot; legal range ≥ 2.
- `LZB`, 1: 1 enables leading-zero blanking; 0 shows all three digits.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load`  in  1  capture `hund`/`ten`/`one` at this edge.
- `hund`  in  4  hundreds BCD digit.
- `ten`  in  4  tens BCD digit.
- `one`  in  4  units BCD digit.
- `en`  in  1  display enable; 0 forces the display dark.
- `an`  out  3  active-low digit enables: `an[2]` hundreds, `an[1]` tens, `an[0]` units.
- `seg`  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- `frame`  out  1  one-cycle pulse at each frame boundary.

## Operation
- **Prescaler**
  - `cnt` counts 0..DIV-1 and wraps to 0.
  - The slot state advances when `cnt` equals DIV-1.
- **Slot FSM**
  - States: S_HUND → S_TEN → S_ONE → S_HUND, cyclic.
  - Each state lasts DIV cycles, so a frame is 3·DIV cycles.
- **Frame boundary**
  - The frame boundary is the edge where S_ONE advances to S_HUND.
  - At that edge, `frame` is registered high for exactly one cycle.
- **Capture and commit**
  - `load`=1 at an edge writes the three digits into the pending registers and sets `pend_v`.
  - When `load` repeats within one frame, the last load wins.
  - At the frame boundary, if `pend_v`=1, the pending digits are copied to the display registers and `pend_v` is cleared.
  - Display registers never change at any other edge.
- **Load coincident with the frame boundary**
  - The digits presented with that `load` are written directly to the display registers.
  - `pend_v` ends at 0.
  - Older pending contents are discarded.
- **Blanking** (LZB=1)
  - Hundreds is blanked when the displayed `hund`=0.
  - Tens is blanked when the hundreds digit is blanked and the displayed `ten`=0.
  - Units is never blanked.
  - A blanked slot drives `an`=3'b111 and `seg`=7'h7F.
  - With LZB=0 nothing is blanked.
- **Digit encoding** (`seg`, active-low)
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Codes 10–15 show a dash, 7'h3F.
  - An invalid code counts as nonzero for blanking.
- **Enable**
  - `en`=0 forces `an`=3'b111 and `seg`=7'h7F.
  - The prescaler, FSM, `load` and commit logic keep running.
  - `frame` still pulses.
- **Active-slot drive**
  - S_HUND drives `an`=3'b011.
  - S_TEN drives `an`=3'b101.
  - S_ONE drives `an`=3'b110.

## Timing
- **Reset**
  - `rst` at any edge, including mid-frame, returns the block to its reset state at that edge.
  - Reset state: `cnt`=0, state S_HUND, pending and display registers 0, `pend_v`=0, `an`=3'b111, `seg`=7'h7F, `frame`=0.
- **Output registering**
  - `an`, `seg` and `frame` are registered.
  - `an`/`seg` lag the FSM state and display registers by exactly one clock.
  - The first edge after `rst` falls drives the hundreds slot.
- **Load-to-display latency**
  - From the load edge to the first edge of the next S_HUND: between 1 and 3·DIV cycles.
  - Outputs show the new digits one cycle after that.
- **Frame pulses**
  - `frame` is high in the cycle after each boundary edge.
  - Consecutive pulses are exactly 3·DIV cycles apart.
- **Inputs**
  - `hund`/`ten`/`one` are sampled only on edges where `load`=1.
  - They are don't-care otherwise.

## Test plan
All scenarios use DIV=4.

- **Reset, no load:** reset with LZB=1, en=1 → hundreds and tens slots dark; units slot `an`=3'b110, `seg`=7'h40. Slots repeat every 12 cycles; `frame` pulses every 12 cycles.
- **Load and commit:** load 1,2,3 mid-frame → display unchanged until the next boundary. Then repeating 4-cycle slots: `an`=011/`seg`=79, `an`=101/`seg`=24, `an`=110/`seg`=30.
- **Blanking and dash:** load 0,0,7 → only the units slot lit, `seg`=78. Load 0,5,0 → tens `seg`=12, units `seg`=40. Load 0,C,1 → tens `seg`=3F (not blanked), units `seg`=79. With LZB=0 and 0,0,7 → `seg`=40, 40, 78.
- **Load collisions:** load 4,5,6 then load 7,8,9 in the same frame → 7,8,9 shown after the boundary. A load of 2,2,2 on the boundary edge → 2,2,2 shown in the next S_HUND slot and `pend_v`=0.
- **Enable and mid-frame reset:** `en`=0 for 20 cycles → `an`=111, `seg`=7F throughout and `frame` still pulses. `rst` asserted in S_TEN → next cycle outputs are at reset values, and the display restarts at S_HUND showing blanked 000.
